// File: rtl/lcd_status_formatter.sv
// lcd_status_formatter
//   Character generator for a 2x16 LCD. It maps a 5-bit character index to an
//   ASCII byte. Program number and PC are shown in decimal. They are converted
//   by a clocked double-dabble engine that handles one bit per clock, for both
//   values at once. The displayed digits change only at a commit edge, so a
//   half-converted snapshot is never visible.
//
//   Optional feature: define LCD_HEX_VIEW_EN to add a hex view on estado_i == 4.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   index_i   character position (0x00-0x0F line 1, 0x10-0x1F line 2)
//   estado_i  display mode code
//   pc_i      current PC value (VAL_WIDTH)
//   prog_i    current program number (VAL_WIDTH)
//   upd_i     request a snapshot and conversion of pc_i/prog_i
//   char_o    registered ASCII byte for index_i
//   busy_o    conversion in progress
//   done_o    one-cycle pulse when new digits become visible
//   ovf_o     last committed snapshot overflowed a digit field
module lcd_status_formatter #(
  parameter int          VAL_WIDTH   = 32,
  parameter int          PC_DIGITS   = 4,
  parameter int          PROG_DIGITS = 2,
  parameter int          SIGNED_VALS = 1,
  parameter logic [31:0] MODE_BOOT   = 32'd1,
  parameter logic [31:0] MODE_READY  = 32'd2,
  parameter logic [31:0] MODE_STATUS = 32'd9999
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           index_i,
  input  logic [31:0]          estado_i,
  input  logic [VAL_WIDTH-1:0] pc_i,
  input  logic [VAL_WIDTH-1:0] prog_i,
  input  logic                 upd_i,
  output logic [7:0]           char_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 ovf_o
);

  localparam int CNT_W = $clog2(VAL_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VAL_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic [VAL_WIDTH-1:0]   mag_pc_q, mag_pc_d, mag_pg_q, mag_pg_d;
  // BCD vectors are sized for the largest field (6 digits); unused columns stay 0.
  logic [23:0]            bcd_pc_q, bcd_pc_d, bcd_pg_q, bcd_pg_d;
  logic                   wovf_pc_q, wovf_pc_d, wovf_pg_q, wovf_pg_d;
  logic                   wneg_pc_q, wneg_pc_d, wneg_pg_q, wneg_pg_d;
  logic [23:0]            disp_pc_q, disp_pc_d, disp_pg_q, disp_pg_d;
  logic                   dneg_pc_q, dneg_pc_d, dneg_pg_q, dneg_pg_d;
  logic                   dovf_pc_q, dovf_pc_d, dovf_pg_q, dovf_pg_d;
  logic                   done_q, done_d;
  logic [7:0]             char_q, char_d;
  logic                   take_snap;
  logic [25:0]            step_pc, step_pg;
  logic [VAL_WIDTH:0]     snap_pc, snap_pg;
  logic [3:0]             col;
  logic                   line2;

  // Returns {negative, magnitude}. The most negative value negates to itself,
  // which, read as unsigned, is exactly the magnitude 2^(VAL_WIDTH-1).
  function automatic logic [VAL_WIDTH:0] snap(input logic [VAL_WIDTH-1:0] v);
    if (SIGNED_VALS != 0 && v[VAL_WIDTH-1]) return {1'b1, (~v) + VAL_WIDTH'(1)};
    return {1'b0, v};
  endfunction

  // One double-dabble step: {bad_column, carry_out, shifted_bcd}.
  function automatic logic [25:0] dabble(input logic [23:0] bcd, input logic in_bit,
                                         input int ndig);
    logic [23:0] adj;
    logic [23:0] sh;
    logic        bad;
    logic        carry;
    adj = bcd;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < ndig) begin
        if (adj[k*4 +: 4] >= 4'd10) bad = 1'b1;
        if (adj[k*4 +: 4] >= 4'd5)  adj[k*4 +: 4] = adj[k*4 +: 4] + 4'd3;
      end
    end
    carry = adj[ndig*4-1];
    sh    = {adj[22:0], in_bit};
    for (int k = 0; k < 6; k++) begin
      if (k >= ndig) sh[k*4 +: 4] = 4'd0;
    end
    return {bad, carry, sh};
  endfunction

  function automatic logic [7:0] str_at(input logic [127:0] s, input int len, input int pos);
    return s[(len-1-pos)*8 +: 8];
  endfunction

  function automatic logic [7:0] digit_char(input logic [23:0] bcd, input logic ovf,
                                            input int d);
    return ovf ? 8'h2A : {4'h3, bcd[d*4 +: 4]};
  endfunction

`ifdef LCD_HEX_VIEW_EN
  logic [31:0] hex_pc_q, hex_pc_d, hex_pg_q, hex_pg_d;
  logic [31:0] pc_ext, pg_ext;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  if (VAL_WIDTH >= 32) begin : g_ext_trunc
    assign pc_ext = pc_i[31:0];
    assign pg_ext = prog_i[31:0];
  end else begin : g_ext_pad
    assign pc_ext = {{(32-VAL_WIDTH){1'b0}}, pc_i};
    assign pg_ext = {{(32-VAL_WIDTH){1'b0}}, prog_i};
  end
`endif

  assign col   = index_i[3:0];
  assign line2 = index_i[4];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    mag_pc_d  = mag_pc_q;
    mag_pg_d  = mag_pg_q;
    bcd_pc_d  = bcd_pc_q;
    bcd_pg_d  = bcd_pg_q;
    wovf_pc_d = wovf_pc_q;
    wovf_pg_d = wovf_pg_q;
    wneg_pc_d = wneg_pc_q;
    wneg_pg_d = wneg_pg_q;
    disp_pc_d = disp_pc_q;
    disp_pg_d = disp_pg_q;
    dneg_pc_d = dneg_pc_q;
    dneg_pg_d = dneg_pg_q;
    dovf_pc_d = dovf_pc_q;
    dovf_pg_d = dovf_pg_q;
    done_d    = 1'b0;
    take_snap = 1'b0;
    snap_pc   = snap(pc_i);
    snap_pg   = snap(prog_i);
    step_pc   = dabble(bcd_pc_q, mag_pc_q[VAL_WIDTH-1], PC_DIGITS);
    step_pg   = dabble(bcd_pg_q, mag_pg_q[VAL_WIDTH-1], PROG_DIGITS);
`ifdef LCD_HEX_VIEW_EN
    hex_pc_d  = hex_pc_q;
    hex_pg_d  = hex_pg_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (upd_i) begin
          take_snap = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (upd_i) pend_d = 1'b1;
        bcd_pc_d  = step_pc[23:0];
        bcd_pg_d  = step_pg[23:0];
        // Overflow is sticky for the whole conversion.
        wovf_pc_d = wovf_pc_q | step_pc[25] | step_pc[24];
        wovf_pg_d = wovf_pg_q | step_pg[25] | step_pg[24];
        mag_pc_d  = mag_pc_q << 1;
        mag_pg_d  = mag_pg_q << 1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        disp_pc_d = bcd_pc_q;
        disp_pg_d = bcd_pg_q;
        dneg_pc_d = wneg_pc_q;
        dneg_pg_d = wneg_pg_q;
        dovf_pc_d = wovf_pc_q;
        dovf_pg_d = wovf_pg_q;
        done_d    = 1'b1;
`ifdef LCD_HEX_VIEW_EN
        hex_pc_d  = pc_ext;
        hex_pg_d  = pg_ext;
`endif
        // A request arriving on the commit edge itself counts as pending too.
        if (pend_q || upd_i) begin
          take_snap = 1'b1;
          pend_d    = 1'b0;
          state_d   = S_SHIFT;
        end else begin
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take_snap) begin
      wneg_pc_d = snap_pc[VAL_WIDTH];
      mag_pc_d  = snap_pc[VAL_WIDTH-1:0];
      wneg_pg_d = snap_pg[VAL_WIDTH];
      mag_pg_d  = snap_pg[VAL_WIDTH-1:0];
      bcd_pc_d  = 24'd0;
      bcd_pg_d  = 24'd0;
      wovf_pc_d = 1'b0;
      wovf_pg_d = 1'b0;
      cnt_d     = '0;
    end

    // Character map: reads only index/estado and the committed display regs.
    char_d = 8'h20;
    if (estado_i == MODE_BOOT) begin
      if (!line2 && col < 4'd9) char_d = str_at("INICIANDO", 9, int'(col));
      if (line2 && col < 4'd7)  char_d = str_at("SISTEMA", 7, int'(col));
    end else if (estado_i == MODE_READY) begin
      if (!line2 && col < 4'd7) char_d = str_at("SISTEMA", 7, int'(col));
      if (line2 && col < 4'd8)  char_d = str_at("INICIADO", 8, int'(col));
    end else if (estado_i == MODE_STATUS) begin
      if (!line2) begin
        if (col < 4'd8)       char_d = str_at("PROGRAMA", 8, int'(col));
        else if (col == 4'd9) char_d = dneg_pg_q ? 8'h2D : 8'h20;
        else if (int'(col) >= 10 && int'(col) < 10 + PROG_DIGITS)
          char_d = digit_char(disp_pg_q, dovf_pg_q, PROG_DIGITS - 1 - (int'(col) - 10));
      end else begin
        if (col < 4'd8)       char_d = str_at("CONTADOR", 8, int'(col));
        else if (col == 4'd9) char_d = dneg_pc_q ? 8'h2D : 8'h20;
        else if (int'(col) >= 10 && int'(col) < 10 + PC_DIGITS)
          char_d = digit_char(disp_pc_q, dovf_pc_q, PC_DIGITS - 1 - (int'(col) - 10));
      end
`ifdef LCD_HEX_VIEW_EN
    end else if (estado_i == 32'd4) begin
      if (col < 4'd3)
        char_d = str_at(line2 ? "PG=" : "PC=", 3, int'(col));
      else if (col < 4'd11)
        char_d = hex_char(line2 ? hex_pg_q[(10 - int'(col))*4 +: 4]
                                : hex_pc_q[(10 - int'(col))*4 +: 4]);
`endif
    end else begin
      if (col >= 4'd5 && col <= 4'd7) char_d = 8'h2D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      mag_pc_q  <= '0;
      mag_pg_q  <= '0;
      bcd_pc_q  <= '0;
      bcd_pg_q  <= '0;
      wovf_pc_q <= 1'b0;
      wovf_pg_q <= 1'b0;
      wneg_pc_q <= 1'b0;
      wneg_pg_q <= 1'b0;
      disp_pc_q <= '0;
      disp_pg_q <= '0;
      dneg_pc_q <= 1'b0;
      dneg_pg_q <= 1'b0;
      dovf_pc_q <= 1'b0;
      dovf_pg_q <= 1'b0;
      done_q    <= 1'b0;
      char_q    <= 8'h20;
`ifdef LCD_HEX_VIEW_EN
      hex_pc_q  <= '0;
      hex_pg_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      mag_pc_q  <= mag_pc_d;
      mag_pg_q  <= mag_pg_d;
      bcd_pc_q  <= bcd_pc_d;
      bcd_pg_q  <= bcd_pg_d;
      wovf_pc_q <= wovf_pc_d;
      wovf_pg_q <= wovf_pg_d;
      wneg_pc_q <= wneg_pc_d;
      wneg_pg_q <= wneg_pg_d;
      disp_pc_q <= disp_pc_d;
      disp_pg_q <= disp_pg_d;
      dneg_pc_q <= dneg_pc_d;
      dneg_pg_q <= dneg_pg_d;
      dovf_pc_q <= dovf_pc_d;
      dovf_pg_q <= dovf_pg_d;
      done_q    <= done_d;
      char_q    <= char_d;
`ifdef LCD_HEX_VIEW_EN
      hex_pc_q  <= hex_pc_d;
      hex_pg_q  <= hex_pg_d;
`endif
    end
  end

  assign char_o = char_q;
  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign ovf_o  = dovf_pc_q | dovf_pg_q;

endmodule

// File: tb/tb_lcd_status_formatter.sv
module tb_lcd_status_formatter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  index_i;
  logic [31:0] estado_i;
  logic [31:0] pc_i;
  logic [31:0] prog_i;
  logic        upd_i;
  logic [7:0]  char_o;
  logic        busy_o;
  logic        done_o;
  logic        ovf_o;

  lcd_status_formatter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .index_i  (index_i),
    .estado_i (estado_i),
    .pc_i     (pc_i),
    .prog_i   (prog_i),
    .upd_i    (upd_i),
    .char_o   (char_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .ovf_o    (ovf_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: values of the last committed snapshot.
  logic [31:0] m_pc  = 32'd0;
  logic [31:0] m_pg  = 32'd0;
  logic [31:0] m_hpc = 32'd0;
  logic [31:0] m_hpg = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint magnitude(input logic [31:0] v);
    longint m;
    m = longint'({32'd0, v});
    if (v[31]) m = 64'h1_0000_0000 - m;
    return m;
  endfunction

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic string num_field(input logic [31:0] v, input int nd);
    longint m;
    string   s;
    m = magnitude(v);
    s = v[31] ? "-" : " ";
    for (int k = nd - 1; k >= 0; k--) begin
      if (m >= pow10(nd)) s = {s, "*"};
      else s = $sformatf("%s%0d", s, (m / pow10(k)) % 10);
    end
    return s;
  endfunction

  function automatic string hex_str(input logic [31:0] v);
    string hx = "0123456789ABCDEF";
    string s  = "";
    for (int k = 7; k >= 0; k--) s = $sformatf("%s%c", s, hx[int'(v[k*4 +: 4])]);
    return s;
  endfunction

  function automatic logic [7:0] model_char(input int est, input int idx);
    string l1, l2, ln;
    int    c;
    if (est == 1) begin
      l1 = "INICIANDO"; l2 = "SISTEMA";
    end else if (est == 2) begin
      l1 = "SISTEMA"; l2 = "INICIADO";
    end else if (est == 9999) begin
      l1 = {"PROGRAMA ", num_field(m_pg, 2)};
      l2 = {"CONTADOR ", num_field(m_pc, 4)};
`ifdef LCD_HEX_VIEW_EN
    end else if (est == 4) begin
      l1 = {"PC=", hex_str(m_hpc)};
      l2 = {"PG=", hex_str(m_hpg)};
`endif
    end else begin
      l1 = "     ---"; l2 = "     ---";
    end
    ln = (idx < 16) ? l1 : l2;
    c  = idx % 16;
    return (c < ln.len()) ? 8'(ln[c]) : 8'h20;
  endfunction

  function automatic logic model_ovf();
    return (magnitude(m_pc) >= pow10(4)) || (magnitude(m_pg) >= pow10(2));
  endfunction

  task automatic sweep(input int est, input string tag);
    estado_i = est;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      index_i = 5'(i);
      @(posedge clk);
      #1;
      chk($sformatf("%s_idx%02h", tag, i), {24'd0, char_o}, {24'd0, model_char(est, i)});
    end
  endtask

  // Pulse upd_i and wait (bounded) for done_o; returns latency and busy cycles.
  task automatic do_update(input logic [31:0] pc, input logic [31:0] pg,
                           output int lat, output int bcnt);
    @(negedge clk);
    pc_i   = pc;
    prog_i = pg;
    upd_i  = 1'b1;
    @(posedge clk);
    #1;
    upd_i = 1'b0;
    lat   = 0;
    bcnt  = 0;
    while (lat < 200) begin
      if (busy_o) bcnt++;
      if (done_o) break;
      @(posedge clk);
      #1;
      lat++;
    end
    m_pc  = pc;
    m_pg  = pg;
    m_hpc = pc;
    m_hpg = pg;
  endtask

  task automatic update_and_check(input logic [31:0] pc, input logic [31:0] pg,
                                  input string tag);
    int lat, bcnt;
    do_update(pc, pg, lat, bcnt);
    chk({tag, "_latency"}, lat, 33);
    chk({tag, "_busy_cycles"}, bcnt, 33);
    chk({tag, "_ovf"}, {31'd0, ovf_o}, {31'd0, model_ovf()});
    @(posedge clk);
    #1;
    chk({tag, "_done_1cyc"}, {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    int est_tab[6];
    int dones;
    logic [31:0] rpc, rpg;
    est_tab = '{1, 2, 9999, 4, 77, 9999};

    rst_n    = 1'b0;
    index_i  = 5'd0;
    estado_i = 32'd9999;
    pc_i     = 32'd0;
    prog_i   = 32'd0;
    upd_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_char", {24'd0, char_o}, 32'h20);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_ovf",  {31'd0, ovf_o},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(9999, "reset_zero");

    // char_o is registered: a new index is not visible before the next edge.
    @(negedge clk); index_i = 5'h00;
    @(posedge clk); #1;
    @(negedge clk); index_i = 5'h01;
    #1;
    chk("char_latency_hold", {24'd0, char_o}, {24'd0, 8'h50});
    @(posedge clk); #1;
    chk("char_latency_new", {24'd0, char_o}, {24'd0, 8'h52});

    update_and_check(32'd1234, 32'd7, "pc1234");
    sweep(9999, "pc1234");
    update_and_check(32'hFFFF_FFFB, 32'd42, "pcm5");
    sweep(9999, "pcm5");
    update_and_check(32'd10000, 32'd3, "pc10000");
    sweep(9999, "pc10000");
    update_and_check(32'h8000_0000, 32'hFFFF_FFFB, "pcmin");
    sweep(9999, "pcmin");
    update_and_check(32'd9999, 32'd100, "pgovf");
    sweep(9999, "pgovf");

    // Several requests during one conversion coalesce into one more conversion
    // whose snapshot is taken at the commit edge.
    @(negedge clk);
    pc_i = 32'd1; prog_i = 32'd3; upd_i = 1'b1;
    @(posedge clk); #1;
    upd_i = 1'b0;
    dones = 0;
    for (int c = 0; c < 150; c++) begin
      if (c == 5 || c == 10 || c == 15) upd_i = 1'b1;
      if (c == 20) pc_i = 32'd42;
      @(posedge clk); #1;
      upd_i = 1'b0;
      if (done_o) dones++;
    end
    chk("coalesce_dones", dones, 2);
    m_pc = 32'd42; m_pg = 32'd3; m_hpc = 32'd42; m_hpg = 32'd3;
    sweep(9999, "coalesce");

    sweep(1, "boot");
    sweep(2, "ready");
    sweep(77, "other");

    update_and_check(32'h00AB_CDEF, 32'h0000_0012, "hex");
    sweep(4, "hex");

    // Randomized snapshots across value ranges and display modes.
    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 2))
        0:       rpc = $urandom_range(0, 9999);
        1:       rpc = -$urandom_range(0, 9999);
        default: rpc = $urandom;
      endcase
      case ($urandom_range(0, 2))
        0:       rpg = $urandom_range(0, 99);
        1:       rpg = -$urandom_range(0, 99);
        default: rpg = $urandom;
      endcase
      update_and_check(rpc, rpg, $sformatf("rnd%0d", it));
      sweep(est_tab[$urandom_range(0, 5)], $sformatf("rnd%0d_mode", it));
      sweep(9999, $sformatf("rnd%0d_status", it));
    end

    // Reset in the middle of a conversion discards it and clears the display.
    estado_i = 32'd9999;
    @(negedge clk); index_i = 5'h00;
    @(negedge clk);
    pc_i = 32'd5555; prog_i = 32'd55; upd_i = 1'b1;
    @(posedge clk); #1;
    upd_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    upd_i = 1'b1;
    @(posedge clk); #1;
    upd_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_char", {24'd0, char_o}, 32'h20);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_done", {31'd0, done_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 32'd0; m_pg = 32'd0; m_hpc = 32'd0; m_hpg = 32'd0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done_o || busy_o) dones++;
    end
    chk("midrst_no_activity", dones, 0);
    chk("midrst_ovf", {31'd0, ovf_o}, 32'd0);
    sweep(9999, "midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
